// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for seq_alu.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned NZP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_W-1:0] OP_AND   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd3;
  localparam logic [OP_W-1:0] OP_LSHF  = 3'd4;
  localparam logic [OP_W-1:0] OP_RSHFL = 3'd5;
  localparam logic [OP_W-1:0] OP_RSHFA = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

  // Condition codes of a zero result.
  localparam logic [NZP_W-1:0] NZP_ZERO = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_LSHF) || (op == OP_RSHFL) || (op == OP_RSHFA);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle between the register-read stage and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);

  logic                      in_valid;
  logic                      in_ready;
  logic [alu_pkg::OP_W-1:0]  op;
  logic [WIDTH-1:0]          a;
  logic [WIDTH-1:0]          b;
  logic [SHAMT_W-1:0]        amount;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          result;
  logic [alu_pkg::NZP_W-1:0] nzp;

  modport master (
    output in_valid, op, a, b, amount, out_ready,
    input  in_ready, out_valid, result, nzp
  );

  modport slave (
    input  in_valid, op, a, b, amount, out_ready,
    output in_ready, out_valid, result, nzp
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU ops plus the NZP generator shared with the shift path.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_nzp_src,
  output logic [WIDTH-1:0] o_result_c,
  output logic [NZP_W-1:0] o_nzp_c
);

  logic w_n;
  logic w_z;

  // Shift ops fall through to PASSA so a zero-count shift returns a.
  always_comb begin
    o_result_c = i_a;
    case (i_op)
      OP_ADD:   o_result_c = i_a + i_b;
      OP_AND:   o_result_c = i_a & i_b;
      OP_XOR:   o_result_c = i_a ^ i_b;
      OP_PASSB: o_result_c = i_b;
      default:  o_result_c = i_a;
    endcase
  end

  assign w_n     = i_nzp_src[WIDTH-1];
  assign w_z     = (i_nzp_src == '0);
  assign o_nzp_c = {w_n, w_z, ~w_n & ~w_z};

endmodule

// File: rtl/seq_alu.sv
// Handshaked LC-3b ALU with an iterative one-bit-per-cycle shifter and NZP codes.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  state_t             r_state;
  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [NZP_W-1:0]   r_nzp;

  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_nzp_src;
  logic [NZP_W-1:0]   w_nzp;

  // One-bit step of the accumulator in the captured direction.
  always_comb begin
    w_shift = r_acc;
    case (r_op)
      OP_LSHF:  w_shift = {r_acc[WIDTH-2:0], 1'b0};
      OP_RSHFL: w_shift = {1'b0, r_acc[WIDTH-1:1]};
      OP_RSHFA: w_shift = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default:  w_shift = r_acc;
    endcase
  end

  assign w_nzp_src = (r_state == SHIFT) ? w_shift : w_alu;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .i_op       (bus.op),
    .i_a        (bus.a),
    .i_b        (bus.b),
    .i_nzp_src  (w_nzp_src),
    .o_result_c (w_alu),
    .o_nzp_c    (w_nzp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_nzp    <= NZP_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift(bus.op) && (bus.amount != '0)) begin
              r_op    <= bus.op;
              r_acc   <= bus.a;
              r_cnt   <= bus.amount;
              r_state <= SHIFT;
            end else begin
              r_result <= w_alu;
              r_nzp    <= w_nzp;
              r_state  <= DONE;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_shift;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result <= w_shift;
            r_nzp    <= w_nzp;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.nzp       = r_nzp;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vectors at WIDTH 16, random sweep at WIDTH 8/16/32.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(16), .SHAMT_W(4)) if16 ();
  seq_alu_if #(.WIDTH(8),  .SHAMT_W(3)) if8  ();
  seq_alu_if #(.WIDTH(32), .SHAMT_W(5)) if32 ();

  seq_alu #(.WIDTH(16), .SHAMT_W(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  seq_alu #(.WIDTH(8),  .SHAMT_W(3)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_alu #(.WIDTH(32), .SHAMT_W(5)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  // Index 0 = WIDTH 16, 1 = WIDTH 8, 2 = WIDTH 32.
  logic        t_valid[ND];
  logic        t_rdy[ND];
  logic [2:0]  t_op[ND];
  logic [31:0] t_a[ND];
  logic [31:0] t_b[ND];
  logic [4:0]  t_amt[ND];

  logic        o_ir[ND];
  logic        o_ov[ND];
  logic [31:0] o_res[ND];
  logic [2:0]  o_nzp[ND];

  assign if16.in_valid  = t_valid[0];
  assign if16.out_ready = t_rdy[0];
  assign if16.op        = t_op[0];
  assign if16.a         = t_a[0][15:0];
  assign if16.b         = t_b[0][15:0];
  assign if16.amount    = t_amt[0][3:0];

  assign if8.in_valid   = t_valid[1];
  assign if8.out_ready  = t_rdy[1];
  assign if8.op         = t_op[1];
  assign if8.a          = t_a[1][7:0];
  assign if8.b          = t_b[1][7:0];
  assign if8.amount     = t_amt[1][2:0];

  assign if32.in_valid  = t_valid[2];
  assign if32.out_ready = t_rdy[2];
  assign if32.op        = t_op[2];
  assign if32.a         = t_a[2];
  assign if32.b         = t_b[2];
  assign if32.amount    = t_amt[2];

  always_comb begin
    o_ir[0]  = if16.in_ready;  o_ov[0] = if16.out_valid;
    o_res[0] = 32'(if16.result); o_nzp[0] = if16.nzp;
    o_ir[1]  = if8.in_ready;   o_ov[1] = if8.out_valid;
    o_res[1] = 32'(if8.result);  o_nzp[1] = if8.nzp;
    o_ir[2]  = if32.in_ready;  o_ov[2] = if32.out_valid;
    o_res[2] = if32.result;      o_nzp[2] = if32.nzp;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 8 : 32);
  endfunction

  // Reference: the arithmetic meaning of each op on a w-bit word.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int amt, input int w);
    logic [63:0]        m, ax, bx, r;
    logic signed [63:0] sx;
    m  = (64'd1 << w) - 64'd1;
    ax = {32'd0, a} & m;
    bx = {32'd0, b} & m;
    sx = ax;
    if (ax[w-1]) sx = ax | ~m;
    case (op)
      OP_ADD:   r = ax + bx;
      OP_AND:   r = ax & bx;
      OP_XOR:   r = ax ^ bx;
      OP_PASSA: r = ax;
      OP_LSHF:  r = ax << amt;
      OP_RSHFL: r = ax >> amt;
      OP_RSHFA: r = 64'(sx >>> amt);
      default:  r = bx;
    endcase
    return 32'(r & m);
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [31:0] r, input int w);
    logic n, z;
    n = r[w-1];
    z = (r == 32'd0);
    return {n, z, ~n & ~z};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          amt;
    logic [31:0] res;
    logic [2:0]  nzp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    t_op[0] = vt[i].op; t_a[0] = vt[i].a; t_b[0] = vt[i].b; t_amt[0] = 5'(vt[i].amt);
    t_valid[0] = 1'b1; t_rdy[0] = 1'b0;
    @(negedge clk);
    t_valid[0] = 1'b0;
    lat = 0;
    while (!o_ov[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    chk($sformatf("vec%0d_result", i), o_res[0], vt[i].res);
    chk($sformatf("vec%0d_nzp", i), 32'(o_nzp[0]), 32'(vt[i].nzp));
    chk($sformatf("vec%0d_busy", i), 32'(o_ir[0]), 32'd0);
    t_rdy[0] = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_released_ov", i), 32'(o_ov[0]), 32'd0);
    chk($sformatf("vec%0d_released_ir", i), 32'(o_ir[0]), 32'd1);
    t_rdy[0] = 1'b0;
  endtask

  logic        pend[ND];
  logic        seen[ND];
  logic [31:0] e_res[ND];
  logic [2:0]  e_nzp[ND];
  int          acc_cyc[ND];
  int          e_gap[ND];
  int          n_acc[ND];
  int          n_res[ND];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int spur;
    vt[0]  = '{OP_ADD,   32'hFFFF, 32'h0002, 0,  32'h0001, 3'b001, 0};
    vt[1]  = '{OP_RSHFA, 32'h8010, 32'h5555, 4,  32'hF801, 3'b100, 4};
    vt[2]  = '{OP_RSHFL, 32'h8010, 32'h5555, 4,  32'h0801, 3'b001, 4};
    vt[3]  = '{OP_LSHF,  32'h1234, 32'h0000, 0,  32'h1234, 3'b001, 0};
    vt[4]  = '{OP_LSHF,  32'h0001, 32'h0000, 15, 32'h8000, 3'b100, 15};
    vt[5]  = '{OP_PASSB, 32'h8000, 32'h7FFF, 3,  32'h7FFF, 3'b001, 0};
    vt[6]  = '{OP_AND,   32'hF0F0, 32'h0FF0, 0,  32'h00F0, 3'b001, 0};
    vt[7]  = '{OP_PASSA, 32'h8000, 32'h0001, 0,  32'h8000, 3'b100, 0};
    vt[8]  = '{OP_XOR,   32'h1234, 32'h1234, 0,  32'h0000, 3'b010, 0};
    vt[9]  = '{OP_RSHFA, 32'h7FFF, 32'h0000, 15, 32'h0000, 3'b010, 15};
    vt[10] = '{OP_LSHF,  32'hFFFF, 32'h0000, 1,  32'hFFFE, 3'b100, 1};
    vt[11] = '{OP_ADD,   32'h7FFF, 32'h0001, 0,  32'h8000, 3'b100, 0};

    for (int d = 0; d < ND; d++) begin
      t_valid[d] = 1'b0; t_rdy[d] = 1'b0; t_op[d] = 3'd0;
      t_a[d] = 32'd0; t_b[d] = 32'd0; t_amt[d] = 5'd0;
      pend[d] = 1'b0; seen[d] = 1'b0; e_res[d] = 32'd0; e_nzp[d] = 3'd0;
      acc_cyc[d] = 0; e_gap[d] = 0; n_acc[d] = 0; n_res[d] = 0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_ir_d%0d", d), 32'(o_ir[d]), 32'd1);
      chk($sformatf("reset_ov_d%0d", d), 32'(o_ov[d]), 32'd0);
      chk($sformatf("reset_result_d%0d", d), o_res[d], 32'd0);
      chk($sformatf("reset_nzp_d%0d", d), 32'(o_nzp[d]), 32'b010);
    end

    for (int i = 0; i < 12; i++) run_vec(i);

    // Back-pressure: result held while out_ready low, queued request waits.
    @(negedge clk);
    t_op[0] = OP_XOR; t_a[0] = 32'h1234; t_b[0] = 32'h1234; t_amt[0] = 5'd0;
    t_valid[0] = 1'b1; t_rdy[0] = 1'b0;
    @(negedge clk);
    t_op[0] = OP_ADD; t_a[0] = 32'h0001; t_b[0] = 32'h0001;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ov_c%0d", i), 32'(o_ov[0]), 32'd1);
      chk($sformatf("bp_result_c%0d", i), o_res[0], 32'd0);
      chk($sformatf("bp_nzp_c%0d", i), 32'(o_nzp[0]), 32'b010);
      chk($sformatf("bp_ir_c%0d", i), 32'(o_ir[0]), 32'd0);
      @(negedge clk);
    end
    t_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ov", 32'(o_ov[0]), 32'd0);
    chk("bp_release_ir", 32'(o_ir[0]), 32'd1);
    t_rdy[0] = 1'b0;
    @(negedge clk);
    t_valid[0] = 1'b0;
    chk("bp_next_ov", 32'(o_ov[0]), 32'd1);
    chk("bp_next_result", o_res[0], 32'h0002);
    chk("bp_next_nzp", 32'(o_nzp[0]), 32'b001);
    t_rdy[0] = 1'b1;
    @(negedge clk);
    t_rdy[0] = 1'b0;

    // Reset in the middle of a 9-step left shift.
    t_op[0] = OP_LSHF; t_a[0] = 32'h0003; t_amt[0] = 5'd9; t_valid[0] = 1'b1;
    @(negedge clk);
    t_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midshift_reset_ir", 32'(o_ir[0]), 32'd1);
    chk("midshift_reset_ov", 32'(o_ov[0]), 32'd0);
    chk("midshift_reset_result", o_res[0], 32'd0);
    chk("midshift_reset_nzp", 32'(o_nzp[0]), 32'b010);
    t_rdy[0] = 1'b1;
    spur = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_ov[0]) spur++;
    end
    chk("midshift_no_spurious_ov", 32'(spur), 32'd0);
    t_rdy[0] = 1'b0;

    // Random sweep across all three widths against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        int w;
        w = width_of(d);
        if (o_ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("rnd_pending_d%0d", d), 32'(pend[d]), 32'd1);
          chk($sformatf("rnd_result_d%0d_n%0d", d, n_res[d]), o_res[d], e_res[d]);
          chk($sformatf("rnd_nzp_d%0d_n%0d", d, n_res[d]), 32'(o_nzp[d]), 32'(e_nzp[d]));
          chk($sformatf("rnd_latency_d%0d_n%0d", d, n_res[d]), 32'(c - acc_cyc[d]), 32'(e_gap[d]));
        end
        if (c >= 2940) begin
          t_valid[d] = 1'b0;
          t_rdy[d]   = 1'b1;
        end else begin
          t_valid[d] = ($urandom_range(0, 2) != 0);
          t_rdy[d]   = ($urandom_range(0, 3) != 0);
          t_op[d]    = 3'($urandom_range(0, 7));
          t_a[d]     = $urandom;
          t_b[d]     = $urandom;
          t_amt[d]   = 5'($urandom_range(0, w - 1));
        end
        if (o_ov[d] && t_rdy[d]) begin
          pend[d] = 1'b0;
          seen[d] = 1'b0;
          n_res[d]++;
        end
        if (t_valid[d] && o_ir[d]) begin
          if (pend[d]) chk($sformatf("rnd_overlap_d%0d", d), 32'd1, 32'd0);
          e_res[d]   = ref_res(t_op[d], t_a[d], t_b[d], int'(t_amt[d]), w);
          e_nzp[d]   = ref_nzp(e_res[d], w);
          e_gap[d]   = (is_shift(t_op[d]) && t_amt[d] != 5'd0) ? int'(t_amt[d]) + 1 : 1;
          acc_cyc[d] = c;
          pend[d]    = 1'b1;
          seen[d]    = 1'b0;
          n_acc[d]++;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rnd_drained_d%0d", d), 32'(pend[d]), 32'd0);
      chk($sformatf("rnd_one_result_per_accept_d%0d", d), 32'(n_res[d]), 32'(n_acc[d]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
